// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: one result bit per cycle, XLEN+1 cycles start-to-done.
// Optional MULDIV_EARLY_OUT_EN finishes divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    logic              a_signed, b_signed, sa, sb, dz, neg_d;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              early;
    logic [XLEN-1:0]   early_res;

    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign sa       = a_signed & a[XLEN-1];
    assign sb       = b_signed & b[XLEN-1];
    assign mag_a    = sa ? -a : a;
    assign mag_b    = sb ? -b : b;
    assign dz       = (b == '0);

    // A zero divisor leaves the quotient at all-ones, so its sign must not be applied.
    always_comb begin
        neg_d = 1'b0;
        if (!op[2])
            neg_d = sa ^ sb;
        else if (!op[1])
            neg_d = (sa ^ sb) & ~dz;
        else
            neg_d = sa;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic ovf;
    assign ovf   = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign early = op[2] ? (dz || ovf) : ((a == '0) || (b == '0));
    always_comb begin
        early_res = '0;
        if (op[2]) begin
            if (dz)
                early_res = op[1] ? a : '1;
            else
                early_res = op[1] ? '0 : a;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // acc_q holds {hi, lo}: multiply keeps the multiplier in lo and shifts right,
    // divide keeps {remainder, dividend/quotient} and shifts left.
    logic [XLEN:0]     mul_sum, rem_sh, trial;
    logic              qbit;
    logic [2*XLEN-1:0] nxt, wide;
    logic [XLEN-1:0]   fld, fin;
    logic              low_sel;

    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign trial   = rem_sh - {1'b0, opnd_q};
    assign qbit    = ~trial[XLEN];
    assign nxt     = op_q[2] ? {(qbit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], qbit}
                             : {mul_sum, acc_q[XLEN-1:1]};
    assign low_sel = (op_q == 3'b000) || (op_q[2] && !op_q[1]);
    assign wide    = (neg_q && !op_q[2]) ? -nxt : nxt;
    assign fld     = low_sel ? wide[XLEN-1:0] : wide[2*XLEN-1:XLEN];
    assign fin     = (neg_q && op_q[2]) ? -fld : fld;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            acc_q  <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start && state != RUN) begin
            op_q   <= op;
            neg_q  <= neg_d;
            opnd_q <= op[2] ? mag_b : mag_a;
            acc_q  <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
            if (early) begin
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= early_res;
                cnt_q  <= '0;
            end else begin
                state <= RUN;
                busy  <= 1'b1;
                done  <= 1'b0;
                cnt_q <= CW'(XLEN);
            end
        end else if (state == RUN) begin
            acc_q <= nxt;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= fin;
            end
        end else if (state == DONE) begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised bench for muldiv_unit against an arithmetic reference model, plus directed
// latency, ignored-start, back-to-back, flush and mid-run reset cases.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [31:0] last_res;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
        longint     sx, sy, ux, uy;
        logic [63:0] p;
        int         ix, iy;
        logic       ovf;
        sx  = longint'(int'(x));
        sy  = longint'(int'(y));
        ux  = longint'({32'b0, x});
        uy  = longint'({32'b0, y});
        ix  = int'(x);
        iy  = int'(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p   = '0;
        case (mop)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(ix / iy);
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'(ix % iy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] mop, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (mop[2] && (y == 0 || (!mop[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        if (!mop[2] && (x == 0 || y == 0))
            return 1;
`endif
        return 33;
    endfunction

    // Issues one operation (from IDLE or the DONE cycle) and checks result, latency and busy.
    // poke_at > 0 drives an extra start so it is sampled at that edge number.
    task automatic run_op(input string tag, input logic [2:0] mop, input logic [31:0] x,
                          input logic [31:0] y, input int poke_at);
        int n, busy_cnt, guard, lat;
        logic [31:0] exp;
        guard = 0;
        while (busy && guard < 200) begin tick(); guard++; end
        op = mop; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        exp = model(mop, x, y);
        lat = latency(mop, x, y);
        n = 1; busy_cnt = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            if (n == poke_at - 1) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_busy"}, busy_cnt, lat - 1);
        last_res = exp;
    endtask

    initial begin
        int seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        last_res = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);

        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mulhu_const", result, 32'hFFFF_FFFE);
        run_op("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mul_const", result, 32'h0000_0001);
        run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_const", result, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu_z", 3'd5, 32'd5, 32'd0, 0);
        run_op("remu_z", 3'd7, 32'd5, 32'd0, 0);
        run_op("div_z_neg", 3'd4, 32'hFFFF_FFF0, 32'd0, 0);
        run_op("mul_zero", 3'd1, 32'd0, 32'h1234_5678, 0);
        run_op("poke", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5);
        run_op("b2b", 3'd0, 32'h0001_0003, 32'h0000_0007, 0);

        // flush mid-run: no done, result held
        tick();
        op = 3'd3; a = 32'hCAFE_F00D; b = 32'h0BAD_0BAD; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        flush = 1'b1; op = 3'd0; a = 32'h5; b = 32'h5; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_result", result, last_res);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) seen++;
        end
        chk("flush_quiet", seen, 0);

        // reset mid-run
        op = 3'd4; a = 32'd1000; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (18) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_result", result, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen++;
        end
        chk("mrst_nodone", seen, 0);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = '0;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) tick();
            run_op("rand", rop, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
